// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that grants one stream at a time to a shared 2:1 mux.
// A grant ends on its last beat, on the beat limit, or when the owner stops sending for too long.
module mux2_rr_arbiter #(
  parameter int WIDTH         = 8,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg;
  logic            grant_reg;
  logic            last_winner_reg;
  logic [BW-1:0]   beat_cnt_reg;
  logic [SW-1:0]   stall_cnt_reg;

  logic             active;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic             xfer;

  // Datapath is purely combinational from the registered grant; nothing is buffered.
  assign active  = (state_reg == GRANT);
  assign g_valid = grant_reg ? req1_valid : req0_valid;
  assign g_last  = grant_reg ? req1_last  : req0_last;
  assign g_data  = grant_reg ? req1_data  : req0_data;

  assign out_valid  = active & g_valid;
  assign out_data   = active ? g_data : '0;
  assign out_last   = active & (g_last | (beat_cnt_reg == BEAT_LAST));
  assign req0_ready = active & ~grant_reg & out_ready;
  assign req1_ready = active &  grant_reg & out_ready;
  assign sel        = grant_reg;
  assign busy       = active;
  assign xfer       = active & g_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      grant_reg       <= 1'b0;
      last_winner_reg <= 1'b1;
      beat_cnt_reg    <= '0;
      stall_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            state_reg <= GRANT;
            if (req0_valid & req1_valid)
              grant_reg <= ~last_winner_reg;
            else
              grant_reg <= req1_valid;
          end
        end
        GRANT: begin
          if (xfer) begin
            if (out_last) begin
              state_reg       <= IDLE;
              last_winner_reg <= grant_reg;
              beat_cnt_reg    <= '0;
              stall_cnt_reg   <= '0;
            end else begin
              beat_cnt_reg  <= beat_cnt_reg + 1'b1;
              stall_cnt_reg <= '0;
            end
          end else if (!g_valid) begin
            // Back-pressure (valid high, out_ready low) leaves the stall count alone.
            if ((STALL_TIMEOUT > 0) && (stall_cnt_reg == STALL_LAST)) begin
              state_reg       <= IDLE;
              last_winner_reg <= grant_reg;
              beat_cnt_reg    <= '0;
              stall_cnt_reg   <= '0;
            end else if (stall_cnt_reg != '1) begin
              stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: queue-driven producers, hand-computed beat lists and timing.
module tb_mux2_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, out_valid, out_last, sel, busy;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int tick_n   = 0;

  logic [7:0] q0_data[$], q1_data[$];
  logic       q0_last[$], q1_last[$];
  logic [7:0] obs_data[$];
  logic       obs_last[$], obs_sel[$];
  int         obs_tick[$];

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4), .STALL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Present the head of each producer queue; an empty queue means valid low.
  task automatic drive();
    req0_valid = (q0_data.size() > 0);
    req0_data  = (q0_data.size() > 0) ? q0_data[0] : 8'h00;
    req0_last  = (q0_last.size() > 0) ? q0_last[0] : 1'b0;
    req1_valid = (q1_data.size() > 0);
    req1_data  = (q1_data.size() > 0) ? q1_data[0] : 8'h00;
    req1_last  = (q1_last.size() > 0) ? q1_last[0] : 1'b0;
  endtask

  task automatic tick();
    logic f0, f1;
    @(negedge clk);
    tick_n++;
    f0 = req0_valid & req0_ready;
    f1 = req1_valid & req1_ready;
    if (out_valid & out_ready) begin
      obs_data.push_back(out_data);
      obs_last.push_back(out_last);
      obs_sel.push_back(sel);
      obs_tick.push_back(tick_n);
      $display("beat tick=%0d sel=%0d data=0x%02h last=%0d", tick_n, sel, out_data, out_last);
    end
    @(posedge clk);
    #1;
    if (f0) begin void'(q0_data.pop_front()); void'(q0_last.pop_front()); end
    if (f1) begin void'(q1_data.pop_front()); void'(q1_last.pop_front()); end
    drive();
    #1;
  endtask

  task automatic do_reset();
    q0_data.delete(); q0_last.delete(); q1_data.delete(); q1_last.delete();
    obs_data.delete(); obs_last.delete(); obs_sel.delete(); obs_tick.delete();
    tick_n = 0;
    out_ready = 1'b1;
    drive();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic exp_beat(input int i, input logic [7:0] d, input logic l, input logic s, input int t);
    if (i >= obs_data.size()) begin
      check($sformatf("beat%0d_count", i), 32'(obs_data.size()), 32'(i + 1));
    end else begin
      check($sformatf("beat%0d_data", i), 32'(obs_data[i]), 32'(d));
      check($sformatf("beat%0d_last", i), 32'(obs_last[i]), 32'(l));
      check($sformatf("beat%0d_sel", i),  32'(obs_sel[i]),  32'(s));
      check($sformatf("beat%0d_tick", i), 32'(obs_tick[i]), 32'(t));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held
    rst = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_ready0", 32'(req0_ready), 32'h0);
    check("rst_ready1", 32'(req1_ready), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single requester, two-beat burst
    do_reset();
    q0_data = '{8'h11, 8'h22}; q0_last = '{1'b0, 1'b1};
    drive(); #1;
    check("t1_idle_busy", 32'(busy), 32'h0);
    tick();
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_sel", 32'(sel), 32'h0);
    check("t1_data0", 32'(out_data), 32'h11);
    check("t1_last0", 32'(out_last), 32'h0);
    check("t1_ready0", 32'(req0_ready), 32'h1);
    tick();
    check("t1_data1", 32'(out_data), 32'h22);
    check("t1_last1", 32'(out_last), 32'h1);
    tick();
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_valid_after", 32'(out_valid), 32'h0);

    // Both requesters busy: alternate 0,1,0,1 with a bubble between bursts
    do_reset();
    q0_data = '{8'h01, 8'h02, 8'h03, 8'h04}; q0_last = '{1'b0, 1'b1, 1'b0, 1'b1};
    q1_data = '{8'h81, 8'h82, 8'h83, 8'h84}; q1_last = '{1'b0, 1'b1, 1'b0, 1'b1};
    drive();
    repeat (13) tick();
    check("t2_count", 32'(obs_data.size()), 32'd8);
    exp_beat(0, 8'h01, 1'b0, 1'b0, 2);
    exp_beat(1, 8'h02, 1'b1, 1'b0, 3);
    exp_beat(2, 8'h81, 1'b0, 1'b1, 5);
    exp_beat(3, 8'h82, 1'b1, 1'b1, 6);
    exp_beat(4, 8'h03, 1'b0, 1'b0, 8);
    exp_beat(5, 8'h04, 1'b1, 1'b0, 9);
    exp_beat(6, 8'h83, 1'b0, 1'b1, 11);
    exp_beat(7, 8'h84, 1'b1, 1'b1, 12);

    // req1 streams 10 beats with no last: forced last every 4th beat, then a stall release
    do_reset();
    for (int i = 0; i < 10; i++) begin
      q1_data.push_back(8'hA0 + 8'(i));
      q1_last.push_back(1'b0);
    end
    drive();
    repeat (20) tick();
    check("t3_busy_t20", 32'(busy), 32'h1);
    tick();
    check("t3_busy_t21", 32'(busy), 32'h0);
    check("t3_count", 32'(obs_data.size()), 32'd10);
    exp_beat(0, 8'hA0, 1'b0, 1'b1, 2);
    exp_beat(3, 8'hA3, 1'b1, 1'b1, 5);
    exp_beat(4, 8'hA4, 1'b0, 1'b1, 7);
    exp_beat(7, 8'hA7, 1'b1, 1'b1, 10);
    exp_beat(8, 8'hA8, 1'b0, 1'b1, 12);
    exp_beat(9, 8'hA9, 1'b0, 1'b1, 13);

    // Back-pressure longer than the stall timeout must not release
    do_reset();
    q1_data = '{8'hB1, 8'hB2, 8'hB3}; q1_last = '{1'b0, 1'b0, 1'b1};
    drive();
    tick(); tick();
    out_ready = 1'b0; #1;
    repeat (10) tick();
    check("t4_ready1", 32'(req1_ready), 32'h0);
    check("t4_valid", 32'(out_valid), 32'h1);
    check("t4_data", 32'(out_data), 32'hB2);
    check("t4_busy", 32'(busy), 32'h1);
    out_ready = 1'b1; #1;
    repeat (3) tick();
    check("t4_busy_after", 32'(busy), 32'h0);
    exp_beat(0, 8'hB1, 1'b0, 1'b1, 2);
    exp_beat(1, 8'hB2, 1'b0, 1'b1, 13);
    exp_beat(2, 8'hB3, 1'b1, 1'b1, 14);

    // req0 stops after one beat; timeout releases, waiting req1 wins next
    do_reset();
    q0_data = '{8'hC1}; q0_last = '{1'b0};
    q1_data = '{8'hD1}; q1_last = '{1'b1};
    drive();
    repeat (5) tick();
    check("t5_valid_stall", 32'(out_valid), 32'h0);
    check("t5_ready1_stall", 32'(req1_ready), 32'h0);
    check("t5_sel_stall", 32'(sel), 32'h0);
    repeat (4) tick();
    check("t5_busy_t9", 32'(busy), 32'h1);
    tick();
    check("t5_busy_t10", 32'(busy), 32'h0);
    check("t5_sel_t10", 32'(sel), 32'h0);
    tick();
    check("t5_sel_t11", 32'(sel), 32'h1);
    check("t5_data_t11", 32'(out_data), 32'hD1);
    check("t5_last_t11", 32'(out_last), 32'h1);
    tick();
    exp_beat(0, 8'hC1, 1'b0, 1'b0, 2);
    exp_beat(1, 8'hD1, 1'b1, 1'b1, 12);

    // Reset during beat 2 of a req1 burst; afterwards a tie goes to req0
    do_reset();
    q0_data = '{8'hE1}; q0_last = '{1'b1};
    q1_data = '{8'hF1, 8'hF2, 8'hF3}; q1_last = '{1'b0, 1'b0, 1'b1};
    drive();
    repeat (4) tick();
    check("t6_sel_mid", 32'(sel), 32'h1);
    check("t6_data_mid", 32'(out_data), 32'hF2);
    rst = 1'b1; #1;
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_ready1", 32'(req1_ready), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_sel", 32'(sel), 32'h0);
    tick();
    rst = 1'b0;
    q0_data.push_back(8'hE5); q0_last.push_back(1'b1);
    drive(); #1;
    check("t6_idle_busy", 32'(busy), 32'h0);
    tick();
    check("t6_tie_sel", 32'(sel), 32'h0);
    check("t6_tie_busy", 32'(busy), 32'h1);
    check("t6_tie_data", 32'(out_data), 32'hE5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
